// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : MIPS fetch front end. Single outstanding imem request, 2-entry
//               {pc, instr} queue toward decode, drives PC enable/next-PC.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    output logic             pc_en,
    output logic [WIDTH-1:0] pc_next,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [31:0]      if_instr,
    output logic [WIDTH-1:0] if_pc
);

    localparam logic [1:0]       c_QCAP    = 2'd2;
    localparam logic [WIDTH-1:0] c_PC_STEP = WIDTH'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_req_pc;
    logic [WIDTH-1:0] r_q_pc    [2];
    logic [31:0]      r_q_instr [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic w_req;
    logic w_grant;
    logic w_push;
    logic w_pop;

    // Credit is checked at issue, so a response always has a free slot.
    assign w_req   = rst && (r_state == S_REQ) && (r_count < c_QCAP) && !redirect;
    assign w_grant = w_req && imem_gnt;
    assign w_push  = (r_state == S_WAIT) && imem_rvalid && !redirect;
    assign w_pop   = if_valid && if_ready && !redirect;

    assign imem_req  = w_req;
    assign imem_addr = pc_in;
    assign pc_en     = rst && (redirect || w_grant);
    assign pc_next   = redirect ? redirect_pc : (pc_in + c_PC_STEP);

    assign if_valid = (r_count != 2'd0);
    assign if_instr = r_q_instr[r_rd_ptr];
    assign if_pc    = r_q_pc[r_rd_ptr];

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_REQ: begin
                if (w_grant) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid)   w_state_nxt = S_REQ;
                else if (redirect) w_state_nxt = S_DROP;
            end
            S_DROP: begin
                if (imem_rvalid) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_REQ;
            r_req_pc <= RESET_PC;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) r_req_pc <= pc_in;
            // Flush wins over any push or pop in the same cycle.
            if (redirect) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
                r_count  <= 2'd0;
            end else begin
                if (w_push) r_wr_ptr <= ~r_wr_ptr;
                if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
                if (w_push && !w_pop)      r_count <= r_count + 2'd1;
                else if (w_pop && !w_push) r_count <= r_count - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]    <= r_req_pc;
            r_q_instr[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch with PC register, imem
//               responder and a queue-based behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_reg;
    logic        pc_en;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    always #5 clk = ~clk;

    instr_fetch #(.WIDTH(32), .RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_reg), .pc_en(pc_en), .pc_next(pc_next),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       pc_reg <= 32'h0000_3000;
        else if (pc_en) pc_reg <= pc_next;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    int total = 0;
    int bad   = 0;

    ent_t        mq[$];
    bit          m_out, m_squash;
    logic [31:0] m_pc;
    bit          e_req;

    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_data;
    int          mem_lat;
    logic [31:0] mem_next_data;

    bit          d_gnt, d_ready, d_redir;
    logic [31:0] d_rpc;

    int          cyc;
    int          first_valid;
    logic [31:0] popped[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        imem_gnt    = d_gnt;
        if_ready    = d_ready;
        redirect    = d_redir;
        redirect_pc = d_rpc;
        imem_rvalid = mem_pend && (mem_cnt == 0);
        imem_rdata  = imem_rvalid ? mem_data : $urandom();
        #1;
        e_req = !m_out && (mq.size() < 2) && !d_redir;
        check("if_valid", if_valid, mq.size() != 0);
        check("imem_req", imem_req, e_req);
        check("pc_en", pc_en, d_redir || (e_req && d_gnt));
        check("pc_next", pc_next, d_redir ? d_rpc : pc_reg + 32'd4);
        if (e_req) check("imem_addr", imem_addr, pc_reg);
        if (mq.size() != 0) begin
            check("if_pc", if_pc, mq[0].pc);
            check("if_instr", if_instr, mq[0].instr);
        end
        if (if_valid && first_valid < 0) first_valid = cyc;
    endtask

    task automatic advance();
        bit   rv;
        ent_t e;
        rv = imem_rvalid;
        if (if_valid && if_ready && !redirect) popped.push_back(if_pc);
        if (rv) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt--;
        if (imem_req && imem_gnt) begin
            mem_pend = 1'b1;
            mem_cnt  = mem_lat - 1;
            mem_data = mem_next_data;
        end
        if (redirect) begin
            mq.delete();
            if (m_out) begin
                if (rv) begin m_out = 1'b0; m_squash = 1'b0; end
                else m_squash = 1'b1;
            end
        end else begin
            if (mq.size() != 0 && if_ready) void'(mq.pop_front());
            if (m_out && rv) begin
                if (!m_squash) begin
                    e.pc    = m_pc;
                    e.instr = imem_rdata;
                    mq.push_back(e);
                end
                m_out    = 1'b0;
                m_squash = 1'b0;
            end
            if (e_req && imem_gnt) begin
                m_out = 1'b1;
                m_pc  = pc_reg;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            advance();
        end
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b1;
        if_ready    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        #1;
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_imem_req", imem_req, 1'b0);
        redirect = 1'b1;
        #1;
        check("rst_pc_en", pc_en, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mq.delete();
        m_out = 0; m_squash = 0; mem_pend = 0;
        cyc = 0; first_valid = -1;
        popped.delete();
        d_gnt = 1; d_ready = 1; d_redir = 0; d_rpc = 32'h0;
        mem_lat = 1; mem_next_data = $urandom();
    endtask

    initial begin
        rst = 1'b1;
        #2;
        do_reset();

        // Zero-wait streaming: one instruction per two cycles.
        drive();
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0000_3000);
        advance();
        step(6);
        check("stream_n", popped.size(), 3);
        check("stream_pc0", popped[0], 32'h0000_3000);
        check("stream_pc1", popped[1], 32'h0000_3004);
        check("stream_pc2", popped[2], 32'h0000_3008);
        check("first_valid", first_valid, 2);

        // Decode back-pressure fills the queue and holds the PC.
        do_reset();
        d_ready = 0;
        step(5);
        drive();
        check("full_req", imem_req, 1'b0);
        check("full_pc_en", pc_en, 1'b0);
        check("full_pc", pc_reg, 32'h0000_3008);
        advance();
        d_ready = 1;
        step(1);
        drive();
        check("resume_req", imem_req, 1'b1);
        check("resume_addr", imem_addr, 32'h0000_3008);
        advance();

        // Redirect while waiting; late response is squashed.
        do_reset();
        mem_lat = 3; mem_next_data = 32'hDEAD_BEEF;
        step(1);
        d_redir = 1; d_rpc = 32'h0000_4000;
        drive();
        check("redir_pc_en", pc_en, 1'b1);
        check("redir_pc_next", pc_next, 32'h0000_4000);
        check("redir_req", imem_req, 1'b0);
        advance();
        d_redir = 0; mem_lat = 1; mem_next_data = $urandom();
        drive();
        check("drop_req", imem_req, 1'b0);
        advance();
        drive();
        check("drop_rvalid", imem_rvalid, 1'b1);
        check("drop_if_valid", if_valid, 1'b0);
        advance();
        drive();
        check("redir_addr", imem_addr, 32'h0000_4000);
        check("redir_req2", imem_req, 1'b1);
        advance();
        step(4);

        // Redirect coincident with response and decode ready.
        do_reset();
        d_ready = 0;
        step(3);
        d_redir = 1; d_rpc = 32'h0000_5000; d_ready = 1;
        drive();
        check("coinc_rvalid", imem_rvalid, 1'b1);
        check("coinc_valid", if_valid, 1'b1);
        advance();
        d_redir = 0;
        drive();
        check("coinc_if_valid", if_valid, 1'b0);
        check("coinc_req", imem_req, 1'b1);
        check("coinc_addr", imem_addr, 32'h0000_5000);
        advance();

        // Grant stall: request held stable.
        do_reset();
        d_gnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive();
            check("stall_req", imem_req, 1'b1);
            check("stall_addr", imem_addr, 32'h0000_3000);
            check("stall_pc_en", pc_en, 1'b0);
            advance();
        end
        d_gnt = 1;
        drive();
        check("gnt_pc_en", pc_en, 1'b1);
        check("gnt_pc_next", pc_next, 32'h0000_3004);
        advance();

        // Asynchronous reset mid-WAIT with one entry queued.
        do_reset();
        d_ready = 0;
        step(2);
        mem_lat = 3;
        step(1);
        check("pre_rst_valid", if_valid, 1'b1);
        do_reset();
        drive();
        check("post_rst_req", imem_req, 1'b1);
        check("post_rst_addr", imem_addr, 32'h0000_3000);
        advance();

        // PC wrap-around.
        do_reset();
        d_redir = 1; d_rpc = 32'hFFFF_FFFC;
        step(1);
        d_redir = 0;
        drive();
        check("wrap_pc_en", pc_en, 1'b1);
        check("wrap_pc_next", pc_next, 32'h0000_0000);
        advance();
        step(3);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            d_gnt   = ($urandom % 10) < 7;
            d_ready = ($urandom % 10) < 6;
            d_redir = ($urandom % 20) == 0;
            d_rpc   = $urandom();
            mem_lat = 1 + int'($urandom % 3);
            mem_next_data = $urandom();
            drive();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
